fifo_burst_scheduler: RTL and testbench

//  Read-side controller for the sample FIFO. Runs on the FIFO read clock and watches the

---
 rtl/fifo_burst_scheduler.sv | 167 ++++++++++++++++
 tb/tb_fifo_burst_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_scheduler.sv
// fifo_burst_scheduler
// Read-side controller for the sample FIFO. It runs in the FIFO read clock
// domain and watches the FIFO status flags. When half-full is reached, it
// sequences fixed-length bursts out of the show-ahead FIFO onto the 16-bit
// host bus. It honours host back-pressure, counts completed bursts and latches
// overflow and underrun as sticky errors.
//
// Ports
//   outputClock    in   FIFO read clock (only clock)
//   nReset         in   asynchronous active-low reset
//   nReady         in   0 = capture enabled / host ready, 1 = stop
//   empty_flag     in   FIFO empty
//   halfFull_flag  in   FIFO level above half
//   full_flag      in   FIFO full
//   fifoData       in   show-ahead FIFO word (10 bits)
//   hostStall      in   host cannot take a word this cycle
//   outputAck      out  FIFO pop request (combinational, BURST only)
//   hostData       out  {6'b0, sample}, valid with hostWrite
//   hostWrite      out  host data strobe, one cycle after outputAck
//   dataAvailable  out  a full burst is buffered (ARM only, one-cycle delay)
//   burstActive    out  state is BURST
//   overflowError  out  sticky: full seen while capturing
//   underrunError  out  sticky: empty seen mid-burst
//   burstCount     out  completed bursts since capture start, wraps
module fifo_burst_scheduler #(
  parameter int BURST_LEN = 8192,
  parameter int CNT_W     = 14
) (
  input  logic        outputClock,
  input  logic        nReset,
  input  logic        nReady,
  input  logic        empty_flag,
  input  logic        halfFull_flag,
  input  logic        full_flag,
  input  logic [9:0]  fifoData,
  input  logic        hostStall,
  output logic        outputAck,
  output logic [15:0] hostData,
  output logic        hostWrite,
  output logic        dataAvailable,
  output logic        burstActive,
  output logic        overflowError,
  output logic        underrunError,
  output logic [15:0] burstCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    BURST = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

  state_t            state_r;
  state_t            nextState_s;
  logic [CNT_W-1:0]  wordCount_r;
  logic [15:0]       hostData_r;
  logic              hostWrite_r;
  logic              dataAvailable_r;
  logic              overflowError_r;
  logic              underrunError_r;
  logic [15:0]       burstCount_r;
  logic              ackEn_s;
  logic              lastWord_s;

  assign lastWord_s = (wordCount_r == LAST_WORD);

  // Pop request: full or stop requests kill the ack in the same cycle they appear.
  always_comb begin
    if (state_r == BURST) begin
      ackEn_s = ~hostStall & ~empty_flag & ~full_flag & ~nReady;
    end else begin
      ackEn_s = 1'b0;
    end
  end

  // Next-state selection; overflow outranks stop, completion and underrun.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (!nReady) nextState_s = ARM;
        else         nextState_s = IDLE;
      end
      ARM: begin
        if (full_flag)                         nextState_s = FAULT;
        else if (nReady)                       nextState_s = IDLE;
        else if (halfFull_flag && !hostStall)  nextState_s = BURST;
        else                                   nextState_s = ARM;
      end
      BURST: begin
        if (full_flag)       nextState_s = FAULT;
        else if (nReady)     nextState_s = IDLE;
        else if (hostStall)  nextState_s = BURST;
        else if (empty_flag) nextState_s = ARM;
        else if (lastWord_s) nextState_s = ARM;
        else                 nextState_s = BURST;
      end
      FAULT: begin
        if (nReady) nextState_s = IDLE;
        else        nextState_s = FAULT;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State register, host pipeline stage, counters and sticky error flags.
  always_ff @(posedge outputClock or negedge nReset) begin
    if (!nReset) begin
      state_r         <= IDLE;
      wordCount_r     <= '0;
      hostData_r      <= 16'd0;
      hostWrite_r     <= 1'b0;
      dataAvailable_r <= 1'b0;
      overflowError_r <= 1'b0;
      underrunError_r <= 1'b0;
      burstCount_r    <= 16'd0;
    end else begin
      state_r     <= nextState_s;
      hostWrite_r <= ackEn_s;
      if (ackEn_s) hostData_r <= {6'd0, fifoData};
      // Gated by the next state so the flag is never seen outside ARM.
      dataAvailable_r <= (nextState_s == ARM) & halfFull_flag;
      case (state_r)
        IDLE: begin
          if (!nReady) begin
            overflowError_r <= 1'b0;
            underrunError_r <= 1'b0;
            burstCount_r    <= 16'd0;
          end
        end
        ARM: begin
          wordCount_r <= '0;
          if (full_flag) overflowError_r <= 1'b1;
        end
        BURST: begin
          if (full_flag) begin
            overflowError_r <= 1'b1;
          end else if (ackEn_s) begin
            wordCount_r <= wordCount_r + CNT_W'(1);
            if (lastWord_s) burstCount_r <= burstCount_r + 16'd1;
          end else if (!nReady && !hostStall && empty_flag) begin
            underrunError_r <= 1'b1;
          end
        end
        FAULT: begin
          wordCount_r <= wordCount_r;
        end
        default: begin
          wordCount_r <= '0;
        end
      endcase
    end
  end

  assign outputAck     = ackEn_s;
  assign hostData      = hostData_r;
  assign hostWrite     = hostWrite_r;
  assign dataAvailable = dataAvailable_r;
  assign burstActive   = (state_r == BURST);
  assign overflowError = overflowError_r;
  assign underrunError = underrunError_r;
  assign burstCount    = burstCount_r;

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// tb_fifo_burst_scheduler
// Self-checking bench for fifo_burst_scheduler (BURST_LEN = 16). A behavioural
// model of the scheduling rules is checked against the DUT every cycle.
// Directed scenarios are followed by a randomized phase. The FIFO is emulated
// as an incrementing sample sequence that advances on every pop.
module tb_fifo_burst_scheduler;

  localparam int BL = 16;
  localparam int MI = 0;
  localparam int MA = 1;
  localparam int MB = 2;
  localparam int MF = 3;

  logic        outputClock = 1'b0;
  logic        nReset = 1'b0;
  logic        nReady = 1'b1;
  logic        empty_flag = 1'b0;
  logic        halfFull_flag = 1'b0;
  logic        full_flag = 1'b0;
  logic [9:0]  fifoData = 10'd0;
  logic        hostStall = 1'b0;
  logic        outputAck;
  logic [15:0] hostData;
  logic        hostWrite;
  logic        dataAvailable;
  logic        burstActive;
  logic        overflowError;
  logic        underrunError;
  logic [15:0] burstCount;

  int checks = 0;
  int errors = 0;
  int wrSeen = 0;

  // model state
  int          mMode;
  int          mDone;
  logic [15:0] mBursts;
  logic        mOvf;
  logic        mUnd;
  logic        mDav;
  logic        mWr;
  logic [15:0] mData;
  logic [9:0]  seq = 10'd0;

  fifo_burst_scheduler #(.BURST_LEN(BL), .CNT_W(5)) dut (
    .outputClock(outputClock), .nReset(nReset), .nReady(nReady),
    .empty_flag(empty_flag), .halfFull_flag(halfFull_flag), .full_flag(full_flag),
    .fifoData(fifoData), .hostStall(hostStall), .outputAck(outputAck),
    .hostData(hostData), .hostWrite(hostWrite), .dataAvailable(dataAvailable),
    .burstActive(burstActive), .overflowError(overflowError),
    .underrunError(underrunError), .burstCount(burstCount)
  );

  always #5 outputClock = ~outputClock;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode = MI; mDone = 0; mBursts = 16'd0;
    mOvf = 1'b0; mUnd = 1'b0; mDav = 1'b0; mWr = 1'b0; mData = 16'd0;
  endtask

  function automatic logic modelAck();
    return nReset && (mMode == MB) && !nReady && !hostStall && !empty_flag && !full_flag;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelClock(input logic ack);
    int nxt;
    nxt = mMode;
    mWr = ack;
    if (ack) mData = {6'd0, fifoData};
    if (mMode == MI) begin
      if (!nReady) begin
        nxt = MA; mOvf = 1'b0; mUnd = 1'b0; mBursts = 16'd0;
      end
    end else if (mMode == MF) begin
      if (nReady) nxt = MI;
    end else begin
      if (full_flag) begin
        mOvf = 1'b1; nxt = MF;
      end else if (nReady) begin
        nxt = MI;
      end else if (mMode == MA) begin
        if (halfFull_flag && !hostStall) begin
          nxt = MB; mDone = 0;
        end
      end else if (ack) begin
        mDone++;
        if (mDone == BL) begin
          mBursts = mBursts + 16'd1; nxt = MA;
        end
      end else if (empty_flag && !hostStall) begin
        mUnd = 1'b1; nxt = MA;
      end
    end
    mDav = (nxt == MA) && halfFull_flag;
    mMode = nxt;
  endtask

  task automatic checkOutputs();
    chk("hostWrite", 16'(hostWrite), 16'(mWr));
    if (mWr) chk("hostData", hostData, mData);
    chk("dataAvailable", 16'(dataAvailable), 16'(mDav));
    chk("burstActive", 16'(burstActive), 16'(mMode == MB));
    chk("overflowError", 16'(overflowError), 16'(mOvf));
    chk("underrunError", 16'(underrunError), 16'(mUnd));
    chk("burstCount", burstCount, mBursts);
    if (hostWrite) wrSeen++;
  endtask

  // One clock cycle: apply inputs after the falling edge, check the ack,
  // clock the model, then check registered outputs on the next falling edge.
  task automatic step(input logic nr, input logic hf, input logic st,
                      input logic em, input logic fu);
    logic ack;
    nReady = nr; halfFull_flag = hf; hostStall = st; empty_flag = em; full_flag = fu;
    #1;
    ack = modelAck();
    chk("outputAck", 16'(outputAck), 16'(ack));
    @(posedge outputClock);
    modelClock(ack);
    @(negedge outputClock);
    checkOutputs();
    if (ack) begin
      seq = seq + 10'd1;
      fifoData = seq;
    end
  endtask

  // Run with a ready host until the model has acked `target` words of a burst.
  task automatic runUntil(input int target);
    int n;
    n = 0;
    while (!(mMode == MB && mDone == target) && n < 60) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 60) begin
      errors++;
      checks++;
      $display("FAIL runUntil: word %0d not reached within cycle budget", target);
    end
  endtask

  initial begin
    int n;
    logic nr;
    modelReset();
    #3;
    chk("reset outputAck", 16'(outputAck), 16'd0);
    chk("reset hostWrite", 16'(hostWrite), 16'd0);
    chk("reset hostData", hostData, 16'd0);
    chk("reset burstActive", 16'(burstActive), 16'd0);
    chk("reset dataAvailable", 16'(dataAvailable), 16'd0);
    chk("reset burstCount", burstCount, 16'd0);
    @(negedge outputClock);
    nReset = 1'b1;

    // 1: plain burst of 16 words
    wrSeen = 0;
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1 burstCount", burstCount, 16'd1);
    chk("s1 writes", 16'(wrSeen), 16'd16);
    chk("s1 last data", hostData, 16'd15);
    chk("s1 back in ARM", 16'(burstActive), 16'd0);
    chk("s1 dataAvailable", 16'(dataAvailable), 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: three stall cycles at word 5
    wrSeen = 0;
    runUntil(5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (mMode != MA && n < 40) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("s2 burstCount", burstCount, 16'd2);
    chk("s2 writes", 16'(wrSeen), 16'd16);
    chk("s2 last data", hostData, 16'd31);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: overflow at word 8, FAULT, stop, restart clears
    runUntil(8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("s3 overflowError", 16'(overflowError), 16'd1);
    chk("s3 burstActive", 16'(burstActive), 16'd0);
    chk("s3 burstCount", burstCount, 16'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s3 overflow cleared", 16'(overflowError), 16'd0);
    chk("s3 burstCount cleared", burstCount, 16'd0);

    // 4: underrun at word 10
    runUntil(10);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s4 underrunError", 16'(underrunError), 16'd1);
    chk("s4 burstCount", burstCount, 16'd0);
    chk("s4 burstActive", 16'(burstActive), 16'd0);

    // 6a: stop at word 4; the last ack's write is already out
    runUntil(4);
    chk("s6 pipelined write", 16'(hostWrite), 16'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s6 stop burstActive", 16'(burstActive), 16'd0);
    chk("s6 stop hostWrite", 16'(hostWrite), 16'd0);
    chk("s6 stop burstCount", burstCount, 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6b: asynchronous reset mid-burst
    runUntil(6);
    nReady = 1'b0; halfFull_flag = 1'b1; hostStall = 1'b0; empty_flag = 1'b0; full_flag = 1'b0;
    #1;
    chk("s6 ack before reset", 16'(outputAck), 16'd1);
    #2;
    nReset = 1'b0;
    #1;
    modelReset();
    chk("s6 reset outputAck", 16'(outputAck), 16'd0);
    chk("s6 reset burstActive", 16'(burstActive), 16'd0);
    chk("s6 reset hostWrite", 16'(hostWrite), 16'd0);
    chk("s6 reset hostData", hostData, 16'd0);
    chk("s6 reset underrunError", 16'(underrunError), 16'd0);
    @(posedge outputClock);
    @(negedge outputClock);
    chk("s6 held ack", 16'(outputAck), 16'd0);
    checkOutputs();
    nReset = 1'b1;

    // randomized phase
    nr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) nr = ~nr;
      if (mMode == MF && $urandom_range(0, 19) == 0) nr = 1'b1;
      step(nr,
           logic'($urandom_range(0, 9) < 8),
           logic'($urandom_range(0, 9) < 2),
           logic'($urandom_range(0, 39) == 0),
           logic'($urandom_range(0, 149) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
